// File: rtl/gb_capture_ctrl.sv
// Captures the Game Boy LCD pixel stream (oversampled in the VGA clock domain) into the 2bpp framebuffer.
// Build option GB_DOUBLE_BUFFER_EN: adds a write-bank MSB on fb_waddr and an fb_bank output.
module gb_capture_ctrl #(
  parameter int H_PIXELS       = 160,
  parameter int V_PIXELS       = 144,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gb_px_clk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  input  logic [1:0]        gb_dat,
  output logic              fb_we,
`ifdef GB_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   fb_waddr,
  output logic              fb_bank,
`else
  output logic [ADDR_W-1:0] fb_waddr,
`endif
  output logic [1:0]        fb_wdata,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              timeout,
  output logic              overrun
);

  localparam int PX_W = $clog2(H_PIXELS + 1);
  localparam int LN_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef GB_DOUBLE_BUFFER_EN
  localparam int WA_W = ADDR_W + 1;
`else
  localparam int WA_W = ADDR_W;
`endif

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        px_sync_q, hs_sync_q, vs_sync_q;
  logic [1:0]        dat_s1_q, dat_s2_q;
  logic [PX_W-1:0]   px_cnt_q, px_cnt_d;
  logic [LN_W-1:0]   line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              we_q, we_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [1:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  logic              ovr_q, ovr_d;
`ifdef GB_DOUBLE_BUFFER_EN
  logic              wbank_q, wbank_d;
  logic              bank_q, bank_d;
`endif

  logic              px_fall, hs_rise, vs_rise;
  logic [PX_W-1:0]   px_t;
  logic [LN_W-1:0]   line_t;
  logic [ADDR_W-1:0] base_t, lin_addr;

  // bit 0/1 are the synchroniser stages, bit 2 holds the previous synchronised level
  assign px_fall = px_sync_q[2] & ~px_sync_q[1];
  assign hs_rise = ~hs_sync_q[2] & hs_sync_q[1];
  assign vs_rise = ~vs_sync_q[2] & vs_sync_q[1];

  always_comb begin
    state_d     = state_q;
    px_cnt_d    = px_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_base_d = line_base_q;
    wd_cnt_d    = wd_cnt_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    tmo_d       = 1'b0;
    ovr_d       = ovr_q;
    px_t        = px_cnt_q;
    line_t      = line_cnt_q;
    base_t      = line_base_q;
    lin_addr    = '0;
`ifdef GB_DOUBLE_BUFFER_EN
    wbank_d     = wbank_q;
    bank_d      = bank_q;
`endif

    if (state_q == DONE) begin
      done_d  = 1'b1;
      valid_d = 1'b1;
`ifdef GB_DOUBLE_BUFFER_EN
      bank_d  = wbank_q;
      wbank_d = ~wbank_q;
`endif
    end

    // vsync restarts the frame from any state and outranks same-cycle pixel/hsync events
    if (vs_rise) begin
      state_d     = ARM;
      px_cnt_d    = '0;
      line_cnt_d  = '0;
      line_base_d = '0;
      wd_cnt_d    = '0;
      ovr_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARM, CAPTURE: begin
          if (hs_rise && px_t != '0) begin
            if (line_t == LN_W'(V_PIXELS - 1)) begin
              ovr_d = 1'b1;
            end else begin
              line_t = line_t + LN_W'(1);
              base_t = base_t + ADDR_W'(H_PIXELS);
              px_t   = '0;
            end
          end
          if (px_fall) begin
            wd_cnt_d = '0;
            if (px_t < PX_W'(H_PIXELS)) begin
              lin_addr = base_t + ADDR_W'(px_t);
`ifdef GB_DOUBLE_BUFFER_EN
              waddr_d  = {wbank_q, lin_addr};
`else
              waddr_d  = lin_addr;
`endif
              we_d     = 1'b1;
              wdata_d  = dat_s2_q;
              state_d  = (line_t == LN_W'(V_PIXELS - 1) && px_t == PX_W'(H_PIXELS - 1)) ? DONE : CAPTURE;
              px_t     = px_t + PX_W'(1);
            end else begin
              ovr_d = 1'b1;
            end
          end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d    = 1'b1;
            valid_d  = 1'b0;
            wd_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
          end
          px_cnt_d    = px_t;
          line_cnt_d  = line_t;
          line_base_d = base_t;
        end
        DONE: begin
          wd_cnt_d = '0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      px_sync_q   <= '0;
      hs_sync_q   <= '0;
      vs_sync_q   <= '0;
      dat_s1_q    <= '0;
      dat_s2_q    <= '0;
      px_cnt_q    <= '0;
      line_cnt_q  <= '0;
      line_base_q <= '0;
      wd_cnt_q    <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef GB_DOUBLE_BUFFER_EN
      wbank_q     <= 1'b0;
      bank_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      px_sync_q   <= {px_sync_q[1:0], gb_px_clk};
      hs_sync_q   <= {hs_sync_q[1:0], gb_hsync};
      vs_sync_q   <= {vs_sync_q[1:0], gb_vsync};
      dat_s1_q    <= gb_dat;
      dat_s2_q    <= dat_s1_q;
      px_cnt_q    <= px_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_base_q <= line_base_d;
      wd_cnt_q    <= wd_cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
`ifdef GB_DOUBLE_BUFFER_EN
      wbank_q     <= wbank_d;
      bank_q      <= bank_d;
`endif
    end
  end

  assign fb_we       = we_q;
  assign fb_waddr    = waddr_q;
  assign fb_wdata    = wdata_q;
  assign frame_done  = done_q;
  assign frame_valid = valid_q;
  assign timeout     = tmo_q;
  assign overrun     = ovr_q;
`ifdef GB_DOUBLE_BUFFER_EN
  assign fb_bank     = bank_q;
`endif

endmodule

// File: tb/tb_gb_capture_ctrl.sv
// Self-checking bench for gb_capture_ctrl on a reduced 20x12 frame geometry with the full watchdog length.
`timescale 1ns/1ps
module tb_gb_capture_ctrl;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int AW = 15;
  localparam int TO = 12500;
`ifdef GB_DOUBLE_BUFFER_EN
  localparam int WA = AW + 1;
`else
  localparam int WA = AW;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gb_px_clk = 1'b1, gb_hsync = 1'b0, gb_vsync = 1'b0;
  logic [1:0] gb_dat = 2'd0;
  logic fb_we, frame_done, frame_valid, timeout, overrun;
  logic [WA-1:0] fb_waddr;
  logic [1:0] fb_wdata;
`ifdef GB_DOUBLE_BUFFER_EN
  logic fb_bank;
`endif

  gb_capture_ctrl #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .gb_px_clk(gb_px_clk), .gb_hsync(gb_hsync), .gb_vsync(gb_vsync),
    .gb_dat(gb_dat), .fb_we(fb_we), .fb_waddr(fb_waddr),
`ifdef GB_DOUBLE_BUFFER_EN
    .fb_bank(fb_bank),
`endif
    .fb_wdata(fb_wdata), .frame_done(frame_done), .frame_valid(frame_valid),
    .timeout(timeout), .overrun(overrun));

  always #20 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [WA-1:0] addr;
    logic [1:0]    data;
    logic          done;
    logic          valid;
    logic          tmo;
    logic          ovr;
    logic          bank;
  } exp_t;

  typedef struct {
    int lines; int px; int tail;
    int exp_wr; int exp_last; int exp_ovr; int exp_done;
  } vec_t;

  int errors = 0, checks = 0;
  int cyc = 0;
  exp_t pipe[$];
  logic cur_rst = 1'b0, cur_px = 1'b1, cur_hs = 1'b0, cur_vs = 1'b0;
  logic [1:0] cur_dat = 2'd0;
  int n_wr = 0, n_done = 0, n_tmo = 0;
  int last_wr_cyc = 0, done_cyc = 0, tmo_cyc = 0;
  logic [WA-1:0] last_addr = '0;

  // reference model: frame position as (line, px), watchdog as a timestamp of the last activity
  bit m_active, m_done_pend, m_ovr, m_valid, m_wbank, m_fbank;
  bit m_ppx, m_phs, m_pvs;
  int m_line, m_px, m_t_last;

  task automatic model_step(output exp_t e);
    bit pf, hr, vr;
    e = '0;
    if (!cur_rst) begin
      m_active = 0; m_done_pend = 0; m_ovr = 0; m_valid = 0; m_wbank = 0; m_fbank = 0;
      m_ppx = 0; m_phs = 0; m_pvs = 0; m_line = 0; m_px = 0; m_t_last = cyc;
    end else begin
      pf = m_ppx & ~cur_px;
      hr = ~m_phs & cur_hs;
      vr = ~m_pvs & cur_vs;
      m_ppx = cur_px; m_phs = cur_hs; m_pvs = cur_vs;
      if (m_done_pend) begin
        e.done = 1; m_valid = 1; m_fbank = m_wbank; m_wbank = ~m_wbank; m_done_pend = 0;
        m_active = 0;
      end
      if (vr) begin
        m_active = 1; m_line = 0; m_px = 0; m_ovr = 0; m_t_last = cyc;
      end else if (m_active) begin
        if (hr && m_px != 0) begin
          if (m_line == V - 1) m_ovr = 1;
          else begin m_line++; m_px = 0; end
        end
        if (pf) begin
          m_t_last = cyc;
          if (m_px < H) begin
            e.we = 1;
            e.addr = WA'(m_line * H + m_px);
`ifdef GB_DOUBLE_BUFFER_EN
            e.addr[AW] = m_wbank;
`endif
            e.data = cur_dat;
            if (m_line == V - 1 && m_px == H - 1) begin m_done_pend = 1; m_active = 0; end
            m_px++;
          end else m_ovr = 1;
        end else if (cyc - m_t_last == TO) begin
          e.tmo = 1; m_valid = 0; m_active = 0;
        end
      end
    end
    e.valid = m_valid; e.ovr = m_ovr; e.bank = m_fbank;
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (fb_we !== e.we || frame_done !== e.done || frame_valid !== e.valid ||
        timeout !== e.tmo || overrun !== e.ovr) begin
      errors++;
      $display("FAIL ctrl@%0d: we,done,valid,tmo,ovr got %b%b%b%b%b exp %b%b%b%b%b", cyc,
               fb_we, frame_done, frame_valid, timeout, overrun, e.we, e.done, e.valid, e.tmo, e.ovr);
    end
    if (e.we) begin
      checks++;
      if (fb_waddr !== e.addr || fb_wdata !== e.data) begin
        errors++;
        $display("FAIL write@%0d: addr/data got %0d/%0d exp %0d/%0d", cyc, fb_waddr, fb_wdata, e.addr, e.data);
      end
    end
`ifdef GB_DOUBLE_BUFFER_EN
    checks++;
    if (fb_bank !== e.bank) begin
      errors++;
      $display("FAIL fb_bank@%0d: got %b exp %b", cyc, fb_bank, e.bank);
    end
`endif
  endtask

  task automatic check_int(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp_v);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    e = pipe.pop_front();
    compare(e);
    if (fb_we === 1'b1) begin n_wr++; last_addr = fb_waddr; last_wr_cyc = cyc; end
    if (frame_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (timeout === 1'b1) begin n_tmo++; tmo_cyc = cyc; end
    rst_n = cur_rst; gb_px_clk = cur_px; gb_hsync = cur_hs; gb_vsync = cur_vs; gb_dat = cur_dat;
    model_step(e);
    if (!cur_rst) begin pipe.delete(); pipe.push_back('0); pipe.push_back('0); end
    pipe.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pixel(input logic [1:0] d, input int lo, input int hi);
    cur_px = 1'b0; cur_dat = d; idle(lo);
    cur_px = 1'b1; idle(hi);
  endtask

  task automatic hsync_pulse();
    cur_hs = 1'b1; idle(2); cur_hs = 1'b0; idle(2);
  endtask

  task automatic vsync_pulse();
    cur_vs = 1'b1; idle(2); cur_vs = 1'b0; idle(2);
  endtask

  task automatic gb_line(input int n);
    hsync_pulse();
    for (int p = 0; p < n; p++) pixel(2'($urandom), 3, 3);
  endtask

  task automatic full_frame(input int per_max);
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      hsync_pulse();
      for (int p = 0; p < H; p++)
        pixel(2'($urandom), $urandom_range(1, per_max), $urandom_range(1, per_max));
    end
    idle(6);
  endtask

  function automatic int outs_or();
    return int'({fb_we, frame_done, frame_valid, timeout, overrun, fb_wdata}) | int'(fb_waddr);
  endfunction

  vec_t vecs[8];
  int w0, d0, t0, k;

  initial begin
    vecs[0] = '{1, 5, 0, 5, 4, 0, 0};
    vecs[1] = '{3, 20, 0, 60, 59, 0, 0};
    vecs[2] = '{2, 21, 0, 40, 39, 1, 0};
    vecs[3] = '{12, 20, 0, 240, 239, 0, 1};
    vecs[4] = '{12, 20, 7, 240, 239, 0, 1};
    vecs[5] = '{4, 20, 9, 89, 88, 0, 0};
    vecs[6] = '{11, 21, 20, 240, 239, 1, 1};
    vecs[7] = '{12, 19, 3, 229, 239, 1, 1};
    for (int i = 0; i < 3; i++) pipe.push_back('0);

    // reset with random GB activity
    cur_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cur_px = 1'($urandom); cur_hs = 1'($urandom); cur_vs = 1'($urandom); cur_dat = 2'($urandom);
      step();
    end
    check_int("reset outputs", outs_or(), 0);
    check_int("reset no writes", n_wr, 0);
    cur_px = 1'b1; cur_hs = 1'b0; cur_vs = 1'b0;
    idle(1);
    cur_rst = 1'b1;
    idle(6);

    // table-driven frame scenarios
    for (int i = 0; i < 8; i++) begin
      w0 = n_wr; d0 = n_done;
      vsync_pulse();
      for (int l = 0; l < vecs[i].lines; l++) gb_line(vecs[i].px);
      if (vecs[i].tail > 0) gb_line(vecs[i].tail);
      idle(8);
      check_int($sformatf("vec%0d writes", i), n_wr - w0, vecs[i].exp_wr);
      check_int($sformatf("vec%0d last addr", i), int'(last_addr[AW-1:0]), vecs[i].exp_last);
      check_int($sformatf("vec%0d overrun", i), int'(overrun), vecs[i].exp_ovr);
      check_int($sformatf("vec%0d frame_done", i), n_done - d0, vecs[i].exp_done);
    end
    check_int("frame_done latency", done_cyc - last_wr_cyc, 1);
    check_int("frame_valid after frame", int'(frame_valid), 1);

    // extra pixel on line 5, then first pixel of line 6
    w0 = n_wr;
    vsync_pulse();
    for (int l = 0; l < 5; l++) gb_line(H);
    k = n_wr;
    gb_line(H + 1);
    idle(4);
    check_int("line5 writes", n_wr - k, H);
    check_int("line5 overrun", int'(overrun), 1);
    gb_line(1);
    idle(4);
    check_int("line6 px0 addr", int'(last_addr[AW-1:0]), 6 * H);
    check_int("overrun frame writes", n_wr - w0, 6 * H + 1);

    // hsync rise and pixel in the same cycle: line advances first
    vsync_pulse();
    gb_line(H); gb_line(H);
    cur_hs = 1'b1; cur_px = 1'b0; cur_dat = 2'd3; idle(3);
    cur_hs = 1'b0; cur_px = 1'b1; idle(5);
    check_int("hsync+px addr", int'(last_addr[AW-1:0]), 2 * H);

    // vsync rise in the same cycle as a pixel event on line 7
    vsync_pulse();
    for (int l = 0; l < 7; l++) gb_line(H);
    gb_line(4);
    w0 = n_wr;
    cur_vs = 1'b1; cur_px = 1'b0; cur_dat = 2'd2; idle(3);
    cur_px = 1'b1; idle(3);
    cur_vs = 1'b0; idle(4);
    check_int("vsync+px dropped", n_wr - w0, 0);
    pixel(2'd1, 3, 3);
    idle(2);
    check_int("restart writes", n_wr - w0, 1);
    check_int("restart addr", int'(last_addr[AW-1:0]), 0);

    // randomized activity against the model
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 2) == 0) cur_px = ~cur_px;
        if ($urandom_range(0, (ph == 0) ? 9 : 150) == 0) cur_hs = ~cur_hs;
        if ($urandom_range(0, 299) == 0) cur_vs = ~cur_vs;
        cur_dat = 2'($urandom);
        step();
      end
      cur_px = 1'b1; cur_hs = 1'b0; cur_vs = 1'b0;
      idle(10);
    end

    // reset in the middle of a frame
    vsync_pulse();
    gb_line(H); gb_line(H); gb_line(7);
    d0 = n_done;
    cur_rst = 1'b0; idle(2);
    check_int("midframe reset outputs", outs_or(), 0);
    cur_rst = 1'b1; idle(6);
    w0 = n_wr;
    gb_line(H); gb_line(H);
    idle(4);
    check_int("post-reset idle writes", n_wr - w0, 0);
    check_int("post-reset no frame_done", n_done - d0, 0);

    // two frames back to back with random pixel periods
    d0 = n_done;
    full_frame(4);
    check_int("frame1 done", n_done - d0, 1);
    check_int("frame1 last addr", int'(last_addr[AW-1:0]), H * V - 1);
`ifdef GB_DOUBLE_BUFFER_EN
    check_int("frame1 write bank", int'(last_addr[AW]), 0);
    check_int("frame1 fb_bank", int'(fb_bank), 0);
`endif
    full_frame(3);
    check_int("frame2 done", n_done - d0, 2);
    check_int("frame2 last addr", int'(last_addr[AW-1:0]), H * V - 1);
`ifdef GB_DOUBLE_BUFFER_EN
    check_int("frame2 write bank", int'(last_addr[AW]), 1);
    check_int("frame2 fb_bank", int'(fb_bank), 1);
`endif

    // watchdog: px clock stops after 10 pixels of line 0
    vsync_pulse();
    gb_line(10);
    t0 = n_tmo; d0 = n_done;
    for (int i = 0; i < TO + 500 && n_tmo == t0; i++) step();
    check_int("timeout seen", n_tmo - t0, 1);
    check_int("timeout distance", tmo_cyc - last_wr_cyc, TO);
    check_int("timeout no frame_done", n_done - d0, 0);
    check_int("timeout clears valid", int'(frame_valid), 0);
    w0 = n_wr;
    gb_line(3);
    idle(4);
    check_int("idle after timeout", n_wr - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
